// File: rtl/uart_pkg.sv
// uart_pkg: shared constants, state encoding and counter-width helper for the UART receiver.
//   DBIT_DEF / SB_TICK_DEF : default data-bit count and stop-bit tick span
//   OS_TICKS / OS_MID      : 16x oversampling period and its mid-point tick
package uart_pkg;
    localparam int DBIT_DEF    = 8;
    localparam int SB_TICK_DEF = 16;
    localparam int OS_TICKS    = 16;
    localparam int OS_MID      = 7;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    // Tick counter must hold both the 0..15 oversampling count and SB_TICK-1.
    function automatic int cnt_w(input int ticks);
        return ($clog2(ticks) > 4) ? $clog2(ticks) : 4;
    endfunction
endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: serial-side inputs and byte-side outputs of the UART receiver.
//   rx, s_tick                 : raw serial line and 16x baud tick (driven by master)
//   dout, rx_done_tick,
//   frame_err, parity_err      : received byte, completion strobe, error flags (driven by slave)
interface uart_rx_if
    import uart_pkg::*;
#(
    parameter int DBIT = DBIT_DEF
);
    logic            rx;
    logic            s_tick;
    logic [DBIT-1:0] dout;
    logic            rx_done_tick;
    logic            frame_err;
    logic            parity_err;

    modport master (
        output rx, s_tick,
        input  dout, rx_done_tick, frame_err, parity_err
    );
    modport slave (
        input  rx, s_tick,
        output dout, rx_done_tick, frame_err, parity_err
    );
endinterface

// File: rtl/rx_sync.sv
// rx_sync: 2-flop synchroniser for the asynchronous rx line; both flops reset to idle-high.
//   clk, reset : system clock, asynchronous active-high reset
//   d_i        : asynchronous input
//   q_o        : synchronised output (2 clk latency)
module rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);
    logic [1:0] sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) sync_q <= 2'b11;
        else       sync_q <= {sync_q[0], d_i};
    end

    assign q_o = sync_q[1];
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled UART receiver (8N1 by default) with framing-error flag.
//   clk, reset : system clock, asynchronous active-high reset
//   bus        : uart_rx_if.slave -- rx, s_tick in; dout, rx_done_tick, frame_err, parity_err out
// Defining UART_RX_PARITY_EN adds one even-parity bit after the data bits and drives parity_err.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DBIT    = DBIT_DEF,
    parameter int SB_TICK = SB_TICK_DEF
) (
    input  logic     clk,
    input  logic     reset,
    uart_rx_if.slave bus
);
    localparam int SW = cnt_w(SB_TICK);
    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;
`ifdef UART_RX_PARITY_EN
    localparam state_t AFTER_DATA = PARITY;
`else
    localparam state_t AFTER_DATA = STOP;
`endif

    state_t          state_q;
    logic [SW-1:0]   s_q;
    logic [NW-1:0]   n_q;
    logic [DBIT-1:0] b_q;
    logic [DBIT-1:0] dout_q;
    logic            done_q;
    logic            ferr_q;
    logic            rx_s;
`ifdef UART_RX_PARITY_EN
    logic            par_q;
    logic            perr_q;
`endif

    rx_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (bus.rx),
        .q_o   (rx_s)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            dout_q  <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (!rx_s) begin
                    state_q <= START;
                    s_q     <= '0;
                end
                START: if (bus.s_tick) begin
                    if (s_q == SW'(OS_MID)) begin
                        // A line that is high again at mid start bit was a glitch.
                        state_q <= rx_s ? IDLE : DATA;
                        s_q     <= '0;
                        n_q     <= '0;
                    end else begin
                        s_q <= s_q + 1'b1;
                    end
                end
                DATA: if (bus.s_tick) begin
                    if (s_q == SW'(OS_TICKS - 1)) begin
                        s_q <= '0;
                        b_q <= {rx_s, b_q[DBIT-1:1]};
                        if (n_q == NW'(DBIT - 1)) state_q <= AFTER_DATA;
                        else                      n_q <= n_q + 1'b1;
                    end else begin
                        s_q <= s_q + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: if (bus.s_tick) begin
                    if (s_q == SW'(OS_TICKS - 1)) begin
                        par_q   <= rx_s;
                        s_q     <= '0;
                        state_q <= STOP;
                    end else begin
                        s_q <= s_q + 1'b1;
                    end
                end
`endif
                STOP: if (bus.s_tick) begin
                    if (s_q == SW'(SB_TICK - 1)) begin
                        state_q <= IDLE;
                        s_q     <= '0;
                        dout_q  <= b_q;
                        ferr_q  <= ~rx_s;
                        done_q  <= 1'b1;
`ifdef UART_RX_PARITY_EN
                        perr_q  <= ^{b_q, par_q};
`endif
                    end else begin
                        s_q <= s_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.dout         = dout_q;
    assign bus.rx_done_tick = done_q;
    assign bus.frame_err    = ferr_q;
`ifdef UART_RX_PARITY_EN
    assign bus.parity_err   = perr_q;
`else
    assign bus.parity_err   = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx with a frame-level expectation queue.
`timescale 1ns/1ps
module tb_uart_rx;
    localparam int TP = 10;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    typedef struct {
        logic [7:0] d;
        logic       fe;
        logic       pe;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   tcnt = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_strobe = 0;
    exp_t exp_q[$];
    logic [7:0] hd;
    logic hf, hp, prev;

    uart_rx_if #(.DBIT(8)) bus ();

    uart_rx #(.DBIT(8), .SB_TICK(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        bus.s_tick = 1'b0;
        forever begin
            @(negedge clk);
            tcnt = (tcnt == TP - 1) ? 0 : tcnt + 1;
            bus.s_tick = (tcnt == 0);
        end
    end

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, a, e);
        end
    endtask

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            while (!bus.s_tick) @(posedge clk);
        end
        #1;
    endtask

    // One frame: start, LSB-first data, optional parity, stop. A bad stop bit
    // is held low long enough to be sampled, then released.
    task automatic send_frame(input logic [7:0] d, input bit ok, input bit par);
        exp_t e;
        bus.rx = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < 8; i++) begin
            bus.rx = d[i];
            wait_ticks(16);
        end
        if (PAR_EN) begin
            bus.rx = par;
            wait_ticks(16);
        end
        e.d  = d;
        e.fe = !ok;
        e.pe = PAR_EN & (^{d, par});
        exp_q.push_back(e);
        if (ok) begin
            bus.rx = 1'b1;
            wait_ticks(16);
        end else begin
            bus.rx = 1'b0;
            wait_ticks(10);
            bus.rx = 1'b1;
            wait_ticks(6);
        end
    endtask

    // Per-cycle check: strobes pop the expectation queue; between strobes the
    // outputs must hold the last popped values.
    initial begin
        exp_t e;
        hd = '0; hf = 1'b0; hp = 1'b0; prev = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                hd = '0; hf = 1'b0; hp = 1'b0; prev = 1'b0;
                exp_q.delete();
            end else begin
                if (bus.rx_done_tick) begin
                    chk("strobe_width", {31'd0, prev}, 32'd0);
                    chk("strobe_expected", {31'd0, exp_q.size() > 0}, 32'd1);
                    n_strobe++;
                    if (exp_q.size() > 0) begin
                        e  = exp_q.pop_front();
                        hd = e.d; hf = e.fe; hp = e.pe;
                    end
                end
                prev = bus.rx_done_tick;
                chk("dout", {24'd0, bus.dout}, {24'd0, hd});
                chk("frame_err", {31'd0, bus.frame_err}, {31'd0, hf});
                chk("parity_err", {31'd0, bus.parity_err}, {31'd0, hp});
            end
        end
    end

    initial begin
        int s0;
        logic [7:0] d;
        bit ok, p;
        reset  = 1'b1;
        bus.rx = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_dout", {24'd0, bus.dout}, 32'd0);
        chk("reset_done", {31'd0, bus.rx_done_tick}, 32'd0);
        chk("reset_ferr", {31'd0, bus.frame_err}, 32'd0);
        chk("reset_perr", {31'd0, bus.parity_err}, 32'd0);
        reset = 1'b0;
        wait_ticks(20);

        s0 = n_strobe;
        send_frame(8'hA5, 1'b1, 1'b0);
        chk("single_count", n_strobe - s0, 1);
        chk("single_dout", {24'd0, bus.dout}, 32'hA5);
        chk("single_ferr", {31'd0, bus.frame_err}, 32'd0);

        s0 = n_strobe;
        bus.rx = 1'b0;
        wait_ticks(3);
        bus.rx = 1'b1;
        wait_ticks(30);
        chk("glitch_count", n_strobe - s0, 0);
        send_frame(8'h3C, 1'b1, 1'b0);
        chk("after_glitch_dout", {24'd0, bus.dout}, 32'h3C);

        send_frame(8'h55, 1'b0, 1'b0);
        chk("ferr_dout", {24'd0, bus.dout}, 32'h55);
        chk("ferr_flag", {31'd0, bus.frame_err}, 32'd1);
        wait_ticks(20);
        send_frame(8'h66, 1'b1, 1'b0);
        chk("ferr_cleared", {31'd0, bus.frame_err}, 32'd0);

        s0 = n_strobe;
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        send_frame(8'h81, 1'b1, 1'b1);
        chk("b2b_count", n_strobe - s0, 3);
        chk("b2b_last", {24'd0, bus.dout}, 32'h81);

        s0 = n_strobe;
        bus.rx = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < 5; i++) begin
            bus.rx = 8'hC3 >> i;
            wait_ticks(16);
        end
        reset = 1'b1;
        #1;
        chk("midrst_dout", {24'd0, bus.dout}, 32'd0);
        chk("midrst_done", {31'd0, bus.rx_done_tick}, 32'd0);
        chk("midrst_ferr", {31'd0, bus.frame_err}, 32'd0);
        bus.rx = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        wait_ticks(40);
        chk("midrst_count", n_strobe - s0, 0);
        send_frame(8'h12, 1'b1, 1'b0);
        chk("after_rst_dout", {24'd0, bus.dout}, 32'h12);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b1);
        chk("parity_good", {31'd0, bus.parity_err}, 32'd0);
        send_frame(8'h07, 1'b1, 1'b0);
        chk("parity_bad", {31'd0, bus.parity_err}, 32'd1);
`endif

        for (int k = 0; k < 12; k++) begin
            d  = 8'($urandom);
            ok = ($urandom_range(0, 4) != 0);
            p  = 1'($urandom);
            send_frame(d, ok, p);
            if (!ok) wait_ticks(20);
            else     wait_ticks($urandom_range(0, 5));
        end

        for (int i = 0; i < 400 && exp_q.size() > 0; i++) @(posedge clk);
        chk("drain", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver that deserialises an asynchronous 8N1 serial line into parallel bytes using the 16x oversampling tick from the baud tick generator. It sits between the board `rx` pin and the byte consumer (FIFO or interface unit). It flags a completed frame with a one-cycle strobe and reports framing errors. Optionally, it checks a parity bit.

## Interface
Parameters:
- `DBIT`, 8: data bits per frame, LSB first.
- `SB_TICK`, 16: `s_tick` pulses spanning the stop bit (16 = 1 stop bit, 32 = 2).

Ports:
- `clk`, in, 1: single system clock, rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `rx`, in, 1: raw serial line. Idles high. Asynchronous to `clk`.
- `s_tick`, in, 1: one-`clk` pulse at 16x the baud rate, from the tick generator.
- `dout`, out, DBIT: last received byte. Stable until the next `rx_done_tick`.
- `rx_done_tick`, out, 1: one-`clk` pulse when `dout`, `frame_err` and `parity_err` are valid.
- `frame_err`, out, 1: stop bit sampled low in the last frame.
- `parity_err`, out, 1: parity mismatch in the last frame. Tied 0 without the macro.

## Operation
**Input synchroniser.** `rx` passes through a 2-flop synchroniser; both flops reset to 1. All logic uses the synchronised `rx_s`.

**State machine** (`IDLE`, `START`, `DATA`, `PARITY`, `STOP`):
- Registers:
  - tick counter `s`, 4 bits, or wide enough for `SB_TICK-1`
  - bit counter `n`, `clog2(DBIT)` bits
  - shift register `b`, DBIT bits
- **IDLE:** when `rx_s == 0`, go to START with `s = 0`. `s_tick` is not required for this transition.
- **START:** on each `s_tick`:
  - if `s == 7` (mid start bit):
    - if `rx_s == 0`, go to DATA with `s = 0`, `n = 0`
    - otherwise the start was a glitch; return to IDLE with no strobe
  - otherwise `s++`
- **DATA:** on each `s_tick`:
  - if `s == 15`: set `s = 0`, `b = {rx_s, b[DBIT-1:1]}`
    - if `n == DBIT-1`, go to PARITY (macro defined) or STOP
    - otherwise `n++`
  - otherwise `s++`
- **PARITY:** on `s_tick` with `s == 15`, latch the parity bit, set `s = 0`, go to STOP. Otherwise `s++`.
- **STOP:** on `s_tick` with `s == SB_TICK-1`, in the same clock edge:
  - `dout <= b`
  - `frame_err <= ~rx_s`
  - `parity_err` updated
  - `rx_done_tick <= 1`
  - return to IDLE

  Otherwise `s++`.

**Strobe and holding.** `rx_done_tick` is high for exactly one `clk` and is never asserted on a start glitch. Between strobes, `dout` and both error flags hold their values.

**Counter behaviour.** `s` advances only on `s_tick`. Between ticks the FSM holds. `s` and `n` never wrap past their terminal values.

**Error frames.** A frame with a framing error still updates `dout` and strobes; the consumer decides whether to discard it.

**Back-to-back frames.** A falling edge immediately after a stop bit is accepted: IDLE→START in the next `clk`.

**Reset.** Reset mid-frame aborts the frame with no strobe. After reset:
- state = IDLE
- `s`, `n`, `b` = 0
- `dout` = 0
- `rx_done_tick`, `frame_err`, `parity_err` = 0
- synchroniser flops = 1

## Timing
- `rx` to `rx_s` latency: 2 `clk`.
- Sampling points:
  - start bit: 8th `s_tick` after START entry (mid-bit)
  - each data/parity bit: every 16 ticks after that
  - stop bit: checked at the `SB_TICK`th tick into STOP
- `rx_done_tick` is registered and asserts the `clk` after the final stop-bit `s_tick`.
- Frame duration (8N1): about 9.5 bit periods from falling edge to strobe, so roughly 152 `s_tick`s.
- Tick tolerance: correct reception up to ±3% baud mismatch.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - the PARITY state is compiled in and one parity bit is expected after the data bits
  - even parity: `parity_err = ^{b, p} != 0`
- `UART_RX_PARITY_EN` undefined:
  - PARITY is removed and DATA goes directly to STOP
  - `parity_err` is constant 0
  - frame format is 8N1

## Structure
- Shared package `uart_pkg`:
  - state encoding constants (IDLE=0 … STOP=4)
  - `DBIT` and `SB_TICK` defaults
  - oversampling constants (16, mid-point 7)
- One sub-module, `rx_sync`: 2-flop synchroniser with asynchronous active-high reset to 1.
- The top level contains the FSM and datapath.

## Test plan
- **Single byte.** Tick every 326 `clk`; send 0xA5 as 8N1. Expect:
  - exactly one `rx_done_tick`
  - `dout = 0xA5`, `frame_err = 0`
- **Start glitch.** Drive `rx` low for 3 ticks only. Expect:
  - no strobe
  - FSM back in IDLE
  - a following 0x3C is received correctly
- **Framing error.** Send 0x55 with the stop bit held low. Expect:
  - strobe with `dout = 0x55`, `frame_err = 1`
  - the next valid frame clears `frame_err` to 0
- **Back-to-back frames.** Send 0x00, 0xFF, 0x81 with no idle gap. Expect:
  - three strobes, in order
  - each strobe exactly 1 `clk` wide
- **Reset mid-frame.** Assert `reset` after data bit 4 of 0xC3. Expect:
  - all outputs 0 immediately
  - no strobe
  - a subsequent 0x12 is received correctly
- **Parity (macro on).** Send 0x07 with parity bit 1, then with parity bit 0. Expect:
  - `parity_err = 0` for the first frame
  - `parity_err = 1` for the second frame
